// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key-sequence controller.
//   PS2_PFX_EXT / PS2_PFX_BRK : set-2 prefix bytes (extended, break)
//   state_t                   : handshake FSM encoding (S_IDLE, S_POP, S_SETTLE)
//   is_prefix()               : true for either prefix byte
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
    endfunction

endpackage

// File: rtl/ps2_key_seq_if.sv
// ps2_key_seq_if: receive-FIFO handshake between ps2_keyboard and its consumer.
//   ready      : FIFO non-empty, data valid
//   data       : FIFO head byte
//   overflow   : FIFO overflow flag
//   nextdata_n : active-low pop strobe from the consumer
// master = FIFO side (ps2_keyboard), slave = consumer side (ps2_key_seq).
interface ps2_key_seq_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    modport master (output ready, output data, output overflow, input nextdata_n);
    modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_prefix_tmo.sv
// ps2_prefix_tmo: lifetime counter for a pending E0/F0 prefix.
//   clk, rst : clock, synchronous active-high reset
//   run      : a prefix flag is pending
//   clr      : a byte is being popped this cycle (restarts the count)
//   expire   : one-cycle pulse after TMO_CYC cycles of run without a pop
module ps2_prefix_tmo #(
    parameter int TMO_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);
    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // A pop in the same cycle wins: the byte is parsed with the flags still set.
    assign expire = run && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/ps2_key_seq.sv
// ps2_key_seq: drains the ps2_keyboard FIFO, parses set-2 scan-code sequences
// (make / F0 break / E0 extended), emits one event per key action, tracks the
// held key and counts distinct presses.
//   clk, rst  : clock, synchronous active-high reset
//   fifo      : FIFO handshake (slave side: ready/data/overflow in, nextdata_n out)
//   evt_*     : event pulse and its code/ext/brk/rpt attributes (held until next event)
//   key_down  : a key is currently held;  key_code : held / last key code
//   press_cnt : non-repeat make events, wrapping;  ovf_seen : sticky overflow
module ps2_key_seq
    import ps2_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_seq_if.slave     fifo,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic             evt_rpt,
    output logic             key_down,
    output logic [7:0]       key_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_seen
);
    state_t state_reg, state_next;
    logic   pop_n;

    logic [7:0]       byte_reg;
    logic             ext_p_reg, brk_p_reg;
    logic             evt_valid_reg, evt_ext_reg, evt_brk_reg, evt_rpt_reg;
    logic [7:0]       evt_code_reg;
    logic             key_down_reg, key_ext_reg;
    logic [7:0]       key_code_reg;
    logic [CNT_W-1:0] press_cnt_reg;
    logic             ovf_seen_reg;

    logic tmo_expire;
    logic in_pop;
    logic same_key;

    // Handshake FSM: one pop per IDLE->POP->SETTLE round; SETTLE lets ready
    // reflect the FIFO after the pop before it is sampled again.
    always_comb begin
        state_next = state_reg;
        pop_n      = 1'b1;
        case (state_reg)
            S_IDLE: begin
                if (fifo.ready) begin
                    state_next = S_POP;
                end
            end
            S_POP: begin
                pop_n      = 1'b0;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign in_pop   = (state_reg == S_POP);
    assign same_key = (byte_reg == key_code_reg) && (ext_p_reg == key_ext_reg);

    ps2_prefix_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .run    (ext_p_reg || brk_p_reg),
        .clr    (in_pop),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            byte_reg      <= '0;
            ext_p_reg     <= 1'b0;
            brk_p_reg     <= 1'b0;
            evt_valid_reg <= 1'b0;
            evt_code_reg  <= '0;
            evt_ext_reg   <= 1'b0;
            evt_brk_reg   <= 1'b0;
            evt_rpt_reg   <= 1'b0;
            key_down_reg  <= 1'b0;
            key_ext_reg   <= 1'b0;
            key_code_reg  <= '0;
            press_cnt_reg <= '0;
            ovf_seen_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            evt_valid_reg <= in_pop && !is_prefix(byte_reg);

            if (fifo.overflow) begin
                ovf_seen_reg <= 1'b1;
            end

            if (state_reg == S_IDLE && fifo.ready) begin
                byte_reg <= fifo.data;
            end

            if (in_pop) begin
                if (byte_reg == PS2_PFX_EXT) begin
                    ext_p_reg <= 1'b1;
                end else if (byte_reg == PS2_PFX_BRK) begin
                    brk_p_reg <= 1'b1;
                end else begin
                    ext_p_reg    <= 1'b0;
                    brk_p_reg    <= 1'b0;
                    evt_code_reg <= byte_reg;
                    evt_ext_reg  <= ext_p_reg;
                    evt_brk_reg  <= brk_p_reg;
                    if (brk_p_reg) begin
                        evt_rpt_reg <= 1'b0;
                        // Release of some other key leaves the held key alone.
                        if (same_key) begin
                            key_down_reg <= 1'b0;
                        end
                    end else if (key_down_reg && same_key) begin
                        evt_rpt_reg <= 1'b1;
                    end else begin
                        evt_rpt_reg   <= 1'b0;
                        key_down_reg  <= 1'b1;
                        key_code_reg  <= byte_reg;
                        key_ext_reg   <= ext_p_reg;
                        press_cnt_reg <= press_cnt_reg + CNT_W'(1);
                    end
                end
            end else if (tmo_expire) begin
                ext_p_reg <= 1'b0;
                brk_p_reg <= 1'b0;
            end
        end
    end

    assign fifo.nextdata_n = pop_n;
    assign evt_valid       = evt_valid_reg;
    assign evt_code        = evt_code_reg;
    assign evt_ext         = evt_ext_reg;
    assign evt_brk         = evt_brk_reg;
    assign evt_rpt         = evt_rpt_reg;
    assign key_down        = key_down_reg;
    assign key_code        = key_code_reg;
    assign press_cnt       = press_cnt_reg;
    assign ovf_seen        = ovf_seen_reg;

endmodule

// File: tb/tb_ps2_key_seq.sv
// tb_ps2_key_seq: scoreboard bench for ps2_key_seq with a behavioural FIFO.
module tb_ps2_key_seq;
    localparam int CNT_W = 8;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_seq_if bus ();

    logic             evt_valid, evt_ext, evt_brk, evt_rpt, key_down, ovf_seen;
    logic [7:0]       evt_code, key_code;
    logic [CNT_W-1:0] press_cnt;

    ps2_key_seq #(.CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (bus),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_brk   (evt_brk),
        .evt_rpt   (evt_rpt),
        .key_down  (key_down),
        .key_code  (key_code),
        .press_cnt (press_cnt),
        .ovf_seen  (ovf_seen)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic       kd;
        logic [7:0] kc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    int         vecs = 0;
    int         errs = 0;
    int         cyc = 0;
    int         last_pop = -100;
    int         pop_low = 0;
    logic       pop_pend;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void expect_evt(logic [7:0] code, logic ext, logic brk, logic rpt,
                                       logic kd, logic [7:0] kc, logic [7:0] cnt);
        exp_t e;
        e.code = code; e.ext = ext; e.brk = brk; e.rpt = rpt;
        e.kd = kd; e.kc = kc; e.cnt = cnt;
        exp_q.push_back(e);
    endfunction

    // Behavioural FIFO: pops when nextdata_n was low across a rising edge.
    initial begin
        bus.ready = 1'b0;
        bus.data  = 8'h00;
        forever begin
            @(negedge clk);
            pop_pend = !bus.nextdata_n;
            @(posedge clk);
            #1;
            if (pop_pend) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                else chk("pop_empty_fifo", 32'd1, 32'd0);
            end
            bus.ready = (fifo_q.size() != 0);
            bus.data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Monitor: compares each event against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!bus.nextdata_n) begin
                pop_low++;
                pop_cyc.push_back(cyc);
                last_pop = cyc;
            end
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_evt", {24'd0, evt_code}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_code", {24'd0, evt_code}, {24'd0, e.code});
                    chk("evt_ext", {31'd0, evt_ext}, {31'd0, e.ext});
                    chk("evt_brk", {31'd0, evt_brk}, {31'd0, e.brk});
                    chk("evt_rpt", {31'd0, evt_rpt}, {31'd0, e.rpt});
                    chk("key_down", {31'd0, key_down}, {31'd0, e.kd});
                    chk("key_code", {24'd0, key_code}, {24'd0, e.kc});
                    chk("press_cnt", {24'd0, press_cnt}, {24'd0, e.cnt});
                    chk("evt_latency", cyc - last_pop, 32'd1);
                    $display("evt cyc=%0d code=%02h ext=%0b brk=%0b rpt=%0b key_down=%0b press_cnt=%0d",
                             cyc, evt_code, evt_ext, evt_brk, evt_rpt, key_down, press_cnt);
                end
            end
        end
    end

    task automatic wait_drain(string name);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({name, "_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_nextdata_n"}, {31'd0, bus.nextdata_n}, 32'd1);
        chk({tag, "_evt_valid"}, {31'd0, evt_valid}, 32'd0);
        chk({tag, "_evt_code"}, {24'd0, evt_code}, 32'd0);
        chk({tag, "_evt_rpt"}, {31'd0, evt_rpt}, 32'd0);
        chk({tag, "_key_down"}, {31'd0, key_down}, 32'd0);
        chk({tag, "_key_code"}, {24'd0, key_code}, 32'd0);
        chk({tag, "_press_cnt"}, {24'd0, press_cnt}, 32'd0);
        chk({tag, "_ovf_seen"}, {31'd0, ovf_seen}, 32'd0);
    endtask

    initial begin
        bus.overflow = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "q" press then release
        pop_low = 0;
        expect_evt(8'h15, 0, 0, 0, 1, 8'h15, 8'd1);
        expect_evt(8'h15, 0, 1, 0, 0, 8'h15, 8'd1);
        fifo_q.push_back(8'h15); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h15);
        wait_drain("q_press_release");
        chk("q_pop_cycles", pop_low, 32'd3);

        // typematic "d": two repeats then release
        expect_evt(8'h23, 0, 0, 0, 1, 8'h23, 8'd2);
        expect_evt(8'h23, 0, 0, 1, 1, 8'h23, 8'd2);
        expect_evt(8'h23, 0, 0, 1, 1, 8'h23, 8'd2);
        expect_evt(8'h23, 0, 1, 0, 0, 8'h23, 8'd2);
        fifo_q.push_back(8'h23); fifo_q.push_back(8'h23); fifo_q.push_back(8'h23);
        fifo_q.push_back(8'hF0); fifo_q.push_back(8'h23);
        wait_drain("typematic");

        // extended key E0 75 / E0 F0 75
        expect_evt(8'h75, 1, 0, 0, 1, 8'h75, 8'd3);
        expect_evt(8'h75, 1, 1, 0, 0, 8'h75, 8'd3);
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'h75);
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h75);
        wait_drain("extended");

        // F0 left pending past the timeout, then a make
        fifo_q.push_back(8'hF0);
        wait_drain("prefix_pop");
        repeat (150) @(negedge clk);
        expect_evt(8'h1C, 0, 0, 0, 1, 8'h1C, 8'd4);
        fifo_q.push_back(8'h1C);
        wait_drain("prefix_timeout");

        // back-to-back burst with an overflow pulse
        pop_cyc.delete();
        expect_evt(8'h2B, 0, 0, 0, 1, 8'h2B, 8'd5);
        expect_evt(8'h2B, 0, 0, 1, 1, 8'h2B, 8'd5);
        expect_evt(8'h34, 0, 0, 0, 1, 8'h34, 8'd6);
        expect_evt(8'h1C, 0, 0, 0, 1, 8'h1C, 8'd7);
        fifo_q.push_back(8'h2B); fifo_q.push_back(8'h2B);
        fifo_q.push_back(8'h34); fifo_q.push_back(8'h1C);
        @(negedge clk);
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.overflow = 1'b0;
        wait_drain("burst");
        chk("burst_pop_count", pop_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++) begin
            chk("burst_pop_spacing", pop_cyc[i] - pop_cyc[i-1], 32'd3);
        end
        chk("ovf_seen_set", {31'd0, ovf_seen}, 32'd1);

        // reset asserted while in POP
        begin
            int n = 0;
            fifo_q.push_back(8'h4D);
            @(negedge clk);
            while (bus.nextdata_n && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_pop", {31'd0, bus.nextdata_n}, 32'd0);
            rst = 1'b1;
            @(negedge clk);
            check_reset_vals("rst_in_pop");
            rst = 1'b0;
            repeat (4) @(negedge clk);
            chk("post_rst_nextdata_n", {31'd0, bus.nextdata_n}, 32'd1);
        end

        // normal operation resumes from a clean state
        expect_evt(8'h15, 0, 0, 0, 1, 8'h15, 8'd1);
        fifo_q.push_back(8'h15);
        wait_drain("after_reset");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
